// File: rtl/core_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// controller states and default geometry.
package core_muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_CNT_W = 5;

    typedef enum logic [1:0] {
        MD_MULLO = 2'd0,
        MD_MULHI = 2'd1,
        MD_DIV   = 2'd2,
        MD_REM   = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/core_muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface core_muldiv_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             start;
    logic [1:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, flush, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, flush, a, b,
        output busy, done, result
    );

endinterface

// File: rtl/core_muldiv_ctrl.sv
// Sequencer for the mul/div unit: IDLE/RUN/DONE state, iteration counter,
// busy/done generation and flush handling.
module core_muldiv_ctrl
    import core_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = MD_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic flush_i,
    input  logic fast_i,
    output logic busy_o,
    output logic done_o,
    output logic load_o,
    output logic step_o,
    output logic last_o
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_o  = 1'b0;
        step_o  = 1'b0;
        last_o  = 1'b0;
        busy_o  = (state_q == S_RUN);
        done_o  = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // flush wins over a same-cycle start
                if (start_i && !flush_i) begin
                    load_o  = 1'b1;
                    state_d = fast_i ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    step_o = 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        last_o  = 1'b1;
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/core_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// The divider datapath exists only when CORE_DIV_EN is defined.
module core_muldiv
    import core_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = MD_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    core_muldiv_if.slave bus
);

    md_op_e             op_in, op_q;
    logic               fast, load, step, last, busy, done;
    logic [WIDTH-1:0]   mcand_q, result_q, result_d;
    logic [2*WIDTH-1:0] prod_q, prod_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_q_next, div_r_next;

    assign op_in = md_op_e'(bus.op);

    core_muldiv_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .start_i (bus.start),
        .flush_i (bus.flush),
        .fast_i  (fast),
        .busy_o  (busy),
        .done_o  (done),
        .load_o  (load),
        .step_o  (step),
        .last_o  (last)
    );

    // Product register holds {partial sum, remaining multiplier bits}.
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_next = {mul_sum, prod_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MD_MULLO;
            mcand_q <= '0;
            prod_q  <= '0;
        end else if (load) begin
            op_q    <= op_in;
            mcand_q <= bus.a;
            prod_q  <= {{WIDTH{1'b0}}, bus.b};
        end else if (step) begin
            prod_q  <= prod_next;
        end
    end

`ifdef CORE_DIV_EN
    logic [WIDTH-1:0] dvsr_q, quot_q, rem_q;
    logic [WIDTH:0]   rem_shift, rem_diff;

    // Dividend bits shift out of quot_q as quotient bits shift in.
    assign rem_shift  = {rem_q, quot_q[WIDTH-1]};
    assign rem_diff   = rem_shift - {1'b0, dvsr_q};
    assign div_r_next = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    assign div_q_next = {quot_q[WIDTH-2:0], ~rem_diff[WIDTH]};
    assign fast       = is_div(op_in) && (bus.b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvsr_q <= '0;
            quot_q <= '0;
            rem_q  <= '0;
        end else if (load) begin
            dvsr_q <= bus.b;
            quot_q <= bus.a;
            rem_q  <= '0;
        end else if (step) begin
            quot_q <= div_q_next;
            rem_q  <= div_r_next;
        end
    end
`else
    assign div_q_next = '0;
    assign div_r_next = '0;
    assign fast       = is_div(op_in);
`endif

    always_comb begin
        result_d = result_q;
        if (load && fast) begin
`ifdef CORE_DIV_EN
            result_d = (op_in == MD_DIV) ? '1 : bus.a;
`else
            result_d = '0;
`endif
        end else if (last) begin
            case (op_q)
                MD_MULLO: result_d = prod_next[WIDTH-1:0];
                MD_MULHI: result_d = prod_next[2*WIDTH-1:WIDTH];
                MD_DIV:   result_d = div_q_next;
                MD_REM:   result_d = div_r_next;
                default:  result_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) result_q <= '0;
        else     result_q <= result_d;
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;

endmodule

// File: tb/tb_core_muldiv.sv
// Self-checking bench for core_muldiv against an arithmetic reference model.
module tb_core_muldiv;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_muldiv_if #(.WIDTH(W)) bus ();

    core_muldiv #(.WIDTH(W), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
`ifdef CORE_DIV_EN
            2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd3: return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
`ifdef CORE_DIV_EN
        if (op >= 2'd2 && b == 0) return 1;
`else
        if (op >= 2'd2) return 1;
`endif
        return 33;
    endfunction

    // Launch one op and wait for done; lat counts edges with the start edge as 1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cyc, output bit timeout);
        res = 'x;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        lat = 1; busy_cyc = 0; timeout = 1'b1;
        #1 bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                timeout = 1'b0;
                res = bus.result;
                break;
            end
            if (bus.busy) busy_cyc++;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        #2;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
        logic [31:0] as  [7] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5};
        logic [31:0] bs  [7] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0};
        logic [31:0] res;
        int lat, bc;
        bit to;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], res, lat, bc, to);
            checks++; if (to) begin failures++; $display("FAIL dir%0d_timeout got=no_done exp=done", i); end
            checks++; if (res !== ref_result(ops[i], as[i], bs[i])) begin
                failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, ref_result(ops[i], as[i], bs[i]));
            end
            checks++; if (lat != ref_latency(ops[i], bs[i])) begin
                failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, ref_latency(ops[i], bs[i]));
            end
            if (i == 0) begin
                checks++; if (bc != 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", bc); end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, res;
        int lat, bc;
        bit to;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = a;
                default: b = $urandom;
            endcase
            issue(op, a, b, res, lat, bc, to);
            checks++; if (to || res !== ref_result(op, a, b) || lat != ref_latency(op, b)) begin
                failures++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d", i, op, a, b, res, lat,
                         ref_result(op, a, b), ref_latency(op, b));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, bc, seen;
        bit to;
        issue(2'd0, 32'd5, 32'd6, res, lat, bc, to);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = $urandom; bus.b = $urandom;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%b exp=1", bus.busy); end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 32'd30) begin failures++; $display("FAIL flush_result got=%h exp=%h", bus.result, 32'd30); end
        bus.flush = 1'b0;
        seen = 0;
        repeat (40) begin @(negedge clk); if (bus.done || bus.busy) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        issue(2'd0, 32'd1234, 32'd5678, res, lat, bc, to);
        checks++; if (to || res !== 32'd7006652 || lat != 33) begin
            failures++; $display("FAIL flush_restart got=%h/%0d exp=%h/33", res, lat, 32'd7006652);
        end
        // flush and start together in IDLE: nothing launches
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd0;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++; $display("FAIL flush_priority busy=%b done=%b exp=0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] res;
        int post;
        bit to;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd9; bus.b = 32'd11;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        to = 1'b1; res = 'x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin to = 1'b0; res = bus.result; break; end
        end
        checks++; if (to || res !== 32'd99) begin failures++; $display("FAIL start_ignored got=%h exp=%h", res, 32'd99); end
        post = 0;
        repeat (40) begin @(negedge clk); if (bus.busy || bus.done) post++; end
        checks++; if (post != 0) begin failures++; $display("FAIL start_not_queued got=%0d exp=0", post); end
        checks++; if (bus.result !== 32'd99) begin failures++; $display("FAIL result_hold got=%h exp=%h", bus.result, 32'd99); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, r1, r2;
        int edges, t1, t2;
        a = $urandom; b = $urandom;
        t1 = -1; t2 = -1; edges = 0; r1 = 'x; r2 = 'x;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = a; bus.b = b;
        for (int i = 0; i < 200 && t2 < 0; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.done) begin
                if (t1 < 0) begin t1 = edges; r1 = bus.result; end
                else begin t2 = edges; r2 = bus.result; bus.start = 1'b0; end
            end
        end
        bus.start = 1'b0;
        checks++; if (t1 != 33) begin failures++; $display("FAIL b2b_first got=%0d exp=33", t1); end
        checks++; if (t2 - t1 != 34) begin failures++; $display("FAIL b2b_interval got=%0d exp=34", t2 - t1); end
        checks++; if (r1 !== ref_result(2'd1, a, b) || r2 !== ref_result(2'd1, a, b)) begin
            failures++; $display("FAIL b2b_result got=%h,%h exp=%h", r1, r2, ref_result(2'd1, a, b));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat, bc, seen;
        bit to;
        issue(2'd0, 32'd3, 32'd7, res, lat, bc, to);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd77; bus.b = 32'd88;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL arst_result got=%h exp=0", bus.result); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin @(negedge clk); if (bus.done || bus.busy) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL arst_no_done got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
